// File: rtl/detect_sequencer_pkg.sv
// Shared definitions for the face-detector frame sequencer: state encoding,
// read-pipe depth, default detection window and the ROI record layout.
package detect_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_STREAM    = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_RESULT    = 3'd5
  } state_t;

  // Cycles between a buffer read strobe and the pixel reaching the detector:
  // one for the memory itself, one for the pixel output register.
  localparam int RD_PIPE_DEPTH = 2;

  // Edge of the unscaled detection window, in pixels.
  localparam int DEFAULT_ROI_SIZE = 24;

  typedef struct packed {
    logic       face;
    logic       timeout;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] w;
    logic [7:0] h;
  } roi_rec_t;

  // base << shamt, clamped to 255; any shift of 8 or more clamps outright.
  function automatic logic [7:0] sat_shift_u8(input logic [7:0] base,
                                              input logic [7:0] shamt);
    logic [15:0] wide;
    logic [7:0]  result;
    wide = {8'h00, base} << shamt[2:0];
    if (shamt >= 8'd8) begin
      result = 8'hFF;
    end else if (wide > 16'd255) begin
      result = 8'hFF;
    end else begin
      result = wide[7:0];
    end
    return result;
  endfunction

endpackage

// File: rtl/detect_sequencer_if.sv
// Result-record channel from the sequencer to the emotion-classifier side.
// The master drives the record and valid; the slave answers with ready.
interface detect_sequencer_if;
  logic       res_valid;
  logic       res_ready;
  logic       res_face;
  logic       res_timeout;
  logic [7:0] res_x;
  logic [7:0] res_y;
  logic [7:0] res_w;
  logic [7:0] res_h;

  modport master (
    output res_valid, res_face, res_timeout, res_x, res_y, res_w, res_h,
    input  res_ready
  );

  modport slave (
    input  res_valid, res_face, res_timeout, res_x, res_y, res_w, res_h,
    output res_ready
  );
endinterface

// File: rtl/detect_sequencer_roi_geom.sv
// Combinational ROI geometry: scales the base window by 2^scale (clamped to
// 255) and clips it against the right/bottom frame border. A detection whose
// anchor lies outside the frame is reported as no face with zero size.
module roi_geom
  import detect_sequencer_pkg::*;
#(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64,
  parameter int ROI_SIZE   = DEFAULT_ROI_SIZE
) (
  input  logic       det_i,
  input  logic [7:0] x_i,
  input  logic [7:0] y_i,
  input  logic [7:0] scale_i,
  output logic       face_o,
  output logic [7:0] w_o,
  output logic [7:0] h_o
);

  localparam logic [15:0] IMG_W16 = 16'(IMG_WIDTH);
  localparam logic [15:0] IMG_H16 = 16'(IMG_HEIGHT);

  logic [7:0]  extent;
  logic [15:0] room_x;
  logic [15:0] room_y;
  logic        in_frame;

  assign extent   = sat_shift_u8(8'(ROI_SIZE), scale_i);
  assign room_x   = IMG_W16 - {8'h00, x_i};
  assign room_y   = IMG_H16 - {8'h00, y_i};
  assign in_frame = ({8'h00, x_i} < IMG_W16) && ({8'h00, y_i} < IMG_H16);

  // Face flag and clipped window size; zero size whenever no face is reported.
  always_comb begin
    face_o = det_i && in_frame;
    w_o    = 8'h00;
    h_o    = 8'h00;
    if (det_i && in_frame) begin
      w_o = ({8'h00, extent} < room_x) ? extent : room_x[7:0];
      h_o = ({8'h00, extent} < room_y) ? extent : room_y[7:0];
    end
  end

endmodule

// File: rtl/detect_sequencer.sv
// Frame-level controller for face_detector: waits for a full frame, pulses
// det_start, streams the buffer in raster order, waits for det_done (bounded
// by a timeout) and hands a registered ROI record to the classifier side.
module detect_sequencer
  import detect_sequencer_pkg::*;
#(
  parameter int IMG_WIDTH      = 64,
  parameter int IMG_HEIGHT     = 64,
  parameter int PIXEL_WIDTH    = 8,
  parameter int ADDR_WIDTH     = 12,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int ROI_SIZE       = DEFAULT_ROI_SIZE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_ready,
  output logic                   frame_release,
  output logic                   mem_rd,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic [PIXEL_WIDTH-1:0] mem_data,
  output logic                   det_start,
  output logic [PIXEL_WIDTH-1:0] det_pixel,
  output logic                   det_pixel_valid,
  input  logic                   det_face_detected,
  input  logic [7:0]             det_face_x,
  input  logic [7:0]             det_face_y,
  input  logic [7:0]             det_face_scale,
  input  logic                   det_done,
  detect_sequencer_if.master     res,
  output logic                   busy,
  output logic [15:0]            frame_count
);

  localparam int                    NUM_PIX    = IMG_WIDTH * IMG_HEIGHT;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(NUM_PIX - 1);
  localparam int                    TMO_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0]      TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]            DRAIN_LAST = 2'(RD_PIPE_DEPTH - 1);

  state_t                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [1:0]               drain_q;
  logic [TMO_W-1:0]         tmo_q;
  logic [RD_PIPE_DEPTH-1:0] rd_pipe_q;
  logic [PIXEL_WIDTH-1:0]   pix_q;
  logic                     busy_q;
  logic [15:0]              frame_cnt_q;
  roi_rec_t                 rec_q, rec_d;

  logic       tmo_hit;
  logic       capture;
  logic       geom_face;
  logic [7:0] geom_w;
  logic [7:0] geom_h;

  // The counter sits at TIMEOUT_CYCLES-1 on the last WAIT_DONE cycle allowed.
  assign tmo_hit = (tmo_q == TMO_LAST);
  assign capture = (state_q == ST_WAIT_DONE) && (det_done || tmo_hit);

  roi_geom #(
    .IMG_WIDTH (IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT),
    .ROI_SIZE  (ROI_SIZE)
  ) u_geom (
    .det_i  (det_face_detected),
    .x_i    (det_face_x),
    .y_i    (det_face_y),
    .scale_i(det_face_scale),
    .face_o (geom_face),
    .w_o    (geom_w),
    .h_o    (geom_h)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; det_done only matters while waiting for it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (frame_ready && !res.res_valid) state_d = ST_START;
      ST_START:     state_d = ST_STREAM;
      ST_STREAM:    if (addr_q == LAST_ADDR) state_d = ST_DRAIN;
      ST_DRAIN:     if (drain_q == DRAIN_LAST) state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (capture) state_d = ST_RESULT;
      ST_RESULT:    if (res.res_ready) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Control outputs decoded from the registered state.
  always_comb begin
    det_start     = (state_q == ST_START);
    mem_rd        = (state_q == ST_STREAM);
    frame_release = (state_q == ST_DRAIN) && (drain_q == DRAIN_LAST);
    res.res_valid = (state_q == ST_RESULT);
  end

  // Record captured on WAIT_DONE exit: a real det_done beats a coincident timeout.
  always_comb begin
    rec_d = rec_q;
    if (capture) begin
      rec_d = '0;
      if (det_done) begin
        rec_d.face = geom_face;
        if (geom_face) begin
          rec_d.x = det_face_x;
          rec_d.y = det_face_y;
          rec_d.w = geom_w;
          rec_d.h = geom_h;
        end
      end else begin
        rec_d.timeout = 1'b1;
      end
    end
  end

  // Address/drain/timeout counters, pixel pipe, record, busy and frame count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q      <= '0;
      drain_q     <= '0;
      tmo_q       <= '0;
      rd_pipe_q   <= '0;
      pix_q       <= '0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
      rec_q       <= '0;
    end else begin
      if (state_q == ST_START) begin
        addr_q <= '0;
      end else if (state_q == ST_STREAM) begin
        addr_q <= addr_q + ADDR_WIDTH'(1);
      end
      drain_q   <= (state_q == ST_DRAIN) ? drain_q + 2'd1 : 2'd0;
      tmo_q     <= (state_q == ST_WAIT_DONE) ? tmo_q + TMO_W'(1) : '0;
      rd_pipe_q <= {rd_pipe_q[RD_PIPE_DEPTH-2:0], mem_rd};
      if (rd_pipe_q[0]) begin
        pix_q <= mem_data;
      end
      busy_q <= (state_d != ST_IDLE);
      rec_q  <= rec_d;
      if (capture) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  assign mem_addr        = addr_q;
  assign det_pixel       = pix_q;
  assign det_pixel_valid = rd_pipe_q[RD_PIPE_DEPTH-1];
  assign busy            = busy_q;
  assign frame_count     = frame_cnt_q;
  assign res.res_face    = rec_q.face;
  assign res.res_timeout = rec_q.timeout;
  assign res.res_x       = rec_q.x;
  assign res.res_y       = rec_q.y;
  assign res.res_w       = rec_q.w;
  assign res.res_h       = rec_q.h;

endmodule

// File: tb/tb_detect_sequencer.sv
// Scoreboard bench for detect_sequencer: a driver runs frames against a
// buffer/detector model and queues expected ROI records; monitors check the
// pixel stream and pop/compare records on every result handshake.
`timescale 1ns/1ps
module tb_detect_sequencer;

  localparam int W   = 64;
  localparam int H   = 64;
  localparam int N   = W * H;
  localparam int TMO = 100;
  localparam int ROI = 24;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_ready = 1'b0;
  logic        frame_release;
  logic        mem_rd;
  logic [11:0] mem_addr;
  logic [7:0]  mem_data = 8'h00;
  logic        det_start;
  logic [7:0]  det_pixel;
  logic        det_pixel_valid;
  logic        det_face_detected = 1'b0;
  logic [7:0]  det_face_x = 8'h00;
  logic [7:0]  det_face_y = 8'h00;
  logic [7:0]  det_face_scale = 8'h00;
  logic        det_done = 1'b0;
  logic        busy;
  logic [15:0] frame_count;

  detect_sequencer_if res_if();

  typedef struct {
    bit face;
    bit tmo;
    int x;
    int y;
    int w;
    int h;
    int cnt;
  } rec_t;

  rec_t       exp_q[$];
  int         tests_run = 0;
  int         tests_failed = 0;
  int         model_count = 0;
  int         hs_count = 0;
  int         rel_count = 0;
  int         pix_idx = 0;
  int         rd_idx = 0;
  logic [7:0] cur_salt = 8'h00;

  always #5 clk = ~clk;

  detect_sequencer #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .PIXEL_WIDTH(8), .ADDR_WIDTH(12),
    .TIMEOUT_CYCLES(TMO), .ROI_SIZE(ROI)
  ) dut (
    .clk(clk), .rst(rst),
    .frame_ready(frame_ready), .frame_release(frame_release),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .det_start(det_start), .det_pixel(det_pixel), .det_pixel_valid(det_pixel_valid),
    .det_face_detected(det_face_detected), .det_face_x(det_face_x),
    .det_face_y(det_face_y), .det_face_scale(det_face_scale), .det_done(det_done),
    .res(res_if), .busy(busy), .frame_count(frame_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Buffer contents of the current frame.
  function automatic logic [7:0] pix_fn(input int a);
    return 8'(a) ^ cur_salt;
  endfunction

  // Reference record straight from the rules: clip(min(255, 24*2^s), edge - pos).
  function automatic rec_t model_rec(input bit det, input int x, input int y,
                                     input int sc, input bit timed_out, input int cnt);
    rec_t r;
    int ext;
    r = '{default: 0};
    r.cnt = cnt;
    if (timed_out) begin
      r.tmo = 1'b1;
    end else if (det && x < W && y < H) begin
      ext = (sc >= 8) ? 255 : (ROI * (1 << sc));
      if (ext > 255) ext = 255;
      r.face = 1'b1;
      r.x = x;
      r.y = y;
      r.w = (ext < W - x) ? ext : W - x;
      r.h = (ext < H - y) ? ext : H - y;
    end
    return r;
  endfunction

  // Buffer memory: data one cycle after the read strobe, garbage otherwise.
  always @(posedge clk) begin
    mem_data <= mem_rd ? pix_fn(int'(mem_addr)) : 8'($urandom);
  end

  // Pixel-stream monitor: addresses in order, pixels in order, release on the last one.
  always @(negedge clk) begin
    if (!rst) begin
      pix_idx = 0;
      rd_idx  = 0;
    end else begin
      if (mem_rd) begin
        check("mem_addr", 64'(mem_addr), 64'(rd_idx));
        rd_idx++;
      end
      if (det_pixel_valid) begin
        check("pixel", 64'(det_pixel), 64'(pix_fn(pix_idx)));
        pix_idx++;
      end
      if (frame_release) begin
        check("release_pixel_count", 64'(pix_idx), 64'(N));
        check("release_read_count", 64'(rd_idx), 64'(N));
        check("release_on_last_valid", 64'(det_pixel_valid), 64'd1);
        rel_count++;
        pix_idx = 0;
        rd_idx  = 0;
      end
    end
  end

  // Record monitor: pop the expected record on each handshake.
  always @(negedge clk) begin : rec_mon
    rec_t e;
    if (rst && res_if.res_valid && res_if.res_ready) begin
      if (exp_q.size() == 0) begin
        check("rec_unexpected", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("rec_face", 64'(res_if.res_face), 64'(e.face));
        check("rec_timeout", 64'(res_if.res_timeout), 64'(e.tmo));
        check("rec_x", 64'(res_if.res_x), 64'(e.x));
        check("rec_y", 64'(res_if.res_y), 64'(e.y));
        check("rec_w", 64'(res_if.res_w), 64'(e.w));
        check("rec_h", 64'(res_if.res_h), 64'(e.h));
        check("rec_frame_count", 64'(frame_count), 64'(e.cnt));
      end
      hs_count++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise frame_ready from IDLE and expect det_start in the next cycle.
  task automatic start_frame(input logic [7:0] salt);
    int k;
    cur_salt    = salt;
    frame_ready = 1'b1;
    k = 0;
    while (!det_start && k < 20) begin
      tick();
      k++;
    end
    check("det_start_seen", 64'(det_start), 64'd1);
    check("start_latency", 64'(k), 64'd1);
    check("busy_in_start", 64'(busy), 64'd1);
    frame_ready = 1'b0;
  endtask

  // From the det_start cycle: optional stray det_done while streaming, then the
  // real det_done 'delay' cycles after the last pixel (negative: never).
  task automatic finish_frame(input bit det, input int x, input int y, input int sc,
                              input int delay, input int stray_at, input bit wait_accept);
    int k;
    int hs0;
    bit timed_out;
    timed_out   = (delay < 0) || (delay > TMO);
    model_count = (model_count + 1) % 65536;
    exp_q.push_back(model_rec(det, x, y, sc, timed_out, model_count));
    k = 0;
    while (!frame_release && k < N + 50) begin
      if (k == stray_at) begin
        det_done = 1'b1;
        det_face_detected = 1'b1;
        det_face_x = 8'd5;
        det_face_y = 8'd5;
        det_face_scale = 8'd0;
      end else begin
        det_done = 1'b0;
      end
      tick();
      k++;
    end
    det_done = 1'b0;
    check("release_seen", 64'(frame_release), 64'd1);
    check("stream_cycles", 64'(k), 64'(N + 2));
    det_face_detected = det;
    det_face_x = 8'(x);
    det_face_y = 8'(y);
    det_face_scale = 8'(sc);
    k = 0;
    while (!res_if.res_valid && k < TMO + 20) begin
      tick();
      k++;
      det_done = (k == delay);
    end
    det_done = 1'b0;
    check("result_latency", 64'(k), timed_out ? 64'(TMO + 1) : 64'(delay + 1));
    if (wait_accept) begin
      hs0 = hs_count;
      k = 0;
      while (hs_count == hs0 && k < 10) begin
        tick();
        k++;
      end
      check("record_accepted", 64'(hs_count), 64'(hs0 + 1));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, 64'({frame_release, mem_rd, mem_addr, det_start, det_pixel,
                               det_pixel_valid, busy, frame_count}), 64'd0);
    check({tag, "_rec"}, 64'({res_if.res_valid, res_if.res_face, res_if.res_timeout,
                              res_if.res_x, res_if.res_y, res_if.res_w, res_if.res_h}), 64'd0);
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int bad;
    int rel0;
    int k;
    rec_t e;
    res_if.res_ready = 1'b1;

    // Reset state
    rst = 1'b0;
    repeat (3) tick();
    check_all_zero("reset_state");
    rst = 1'b1;
    tick();

    // Nominal frame: face (10,12) scale 0, det_done 50 cycles after the last pixel
    start_frame(8'h00);
    finish_frame(1'b1, 10, 12, 0, 50, -1, 1'b1);

    // Geometry boundaries
    start_frame(8'h5A);
    finish_frame(1'b1, 50, 3, 1, 7, -1, 1'b1);
    start_frame(8'hC3);
    finish_frame(1'b1, 0, 0, 4, 12, -1, 1'b1);
    start_frame(8'h11);
    finish_frame(1'b1, 5, 70, 0, 3, -1, 1'b1);

    // det_done on the same cycle the timeout would fire: det_done wins
    start_frame(8'h22);
    finish_frame(1'b1, 20, 20, 2, TMO, -1, 1'b1);

    // Timeout: det_done never arrives
    start_frame(8'h33);
    finish_frame(1'b1, 1, 1, 0, -1, -1, 1'b1);

    // Randomized frames
    for (int i = 0; i < 2; i++) begin
      start_frame(8'($urandom));
      finish_frame(1'($urandom), int'($urandom_range(0, 80)), int'($urandom_range(0, 80)),
                   int'($urandom_range(0, 9)), int'($urandom_range(1, TMO - 1)), -1, 1'b1);
    end

    // No face, with a stray det_done during streaming
    start_frame(8'h77);
    finish_frame(1'b0, 9, 9, 0, 30, 500, 1'b1);

    // Backpressure: record held 500 cycles with frame_ready high
    res_if.res_ready = 1'b0;
    start_frame(8'h44);
    finish_frame(1'b1, 30, 40, 0, 20, -1, 1'b0);
    frame_ready = 1'b1;
    e = exp_q[0];
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      if (det_start || !res_if.res_valid || res_if.res_face !== e.face ||
          res_if.res_timeout !== e.tmo || res_if.res_x !== 8'(e.x) ||
          res_if.res_y !== 8'(e.y) || res_if.res_w !== 8'(e.w) || res_if.res_h !== 8'(e.h))
        bad++;
      tick();
    end
    check("backpressure_unstable_cycles", 64'(bad), 64'd0);
    res_if.res_ready = 1'b1;
    tick();
    check("bp_no_start_after_hs", 64'(det_start), 64'd0);
    check("bp_idle_after_hs", 64'(busy), 64'd0);
    cur_salt = 8'h99;
    tick();
    check("bp_start_2_after_hs", 64'(det_start), 64'd1);
    frame_ready = 1'b0;
    finish_frame(1'b1, 63, 63, 9, 40, -1, 1'b1);

    // Reset in the middle of streaming
    start_frame(8'hAB);
    k = 0;
    while (pix_idx < 1000 && k < 2000) begin
      tick();
      k++;
    end
    check("reached_pixel_1000", 64'(pix_idx >= 1000), 64'd1);
    rel0 = rel_count;
    rst = 1'b0;
    tick();
    check_all_zero("midframe_reset");
    rst = 1'b1;
    model_count = 0;
    start_frame(8'hAB);
    finish_frame(1'b1, 10, 12, 0, 15, -1, 1'b1);
    check("releases_across_reset", 64'(rel_count), 64'(rel0 + 1));

    check("records_outstanding", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
